// File: rtl/bsg_manycore_host_req_pkg.sv
// Shared constants, word-index enum and helpers for the host request FIFO.
// Optional feature macro: BSG_HOST_REQ_FIFO_TIMESTAMP_EN (adds a 5th timestamp word).
package bsg_manycore_host_req_pkg;

  localparam int unsigned host_req_base_words_gp   = 4;
  localparam int unsigned host_req_ts_words_gp     = 5;
`ifdef BSG_HOST_REQ_FIFO_TIMESTAMP_EN
  localparam int unsigned host_req_words_gp        = host_req_ts_words_gp;
`else
  localparam int unsigned host_req_words_gp        = host_req_base_words_gp;
`endif
  localparam int unsigned host_req_word_width_gp   = 32;
  localparam int unsigned host_req_we_bit_gp       = 4;
  localparam int unsigned host_req_src_y_offset_gp = 16;

  typedef enum logic [2:0] {
    E_DATA    = 3'd0,
    E_ADDR    = 3'd1,
    E_MASK_WE = 3'd2,
    E_SRC     = 3'd3,
    E_TIME    = 3'd4
  } host_req_word_e;

  localparam host_req_word_e host_req_last_word_gp =
    host_req_word_e'(3'(host_req_words_gp - 32'd1));

  function automatic host_req_word_e host_req_next_word(input host_req_word_e idx);
    return (idx == host_req_last_word_gp) ? E_DATA : host_req_word_e'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/bsg_manycore_host_req_word_sel.sv
// Selects the 32-bit word of the head packet addressed by word_idx.
// Optional feature macro: BSG_HOST_REQ_FIFO_TIMESTAMP_EN.
module bsg_manycore_host_req_word_sel
  import bsg_manycore_host_req_pkg::*;
(
  input  logic [host_req_words_gp*32-1:0] entry_i,
  input  logic                            v_i,
  input  host_req_word_e                  word_idx_i,
  output logic [31:0]                     data_o
);

  // Word multiplexer, forced to zero when no packet is held.
  always_comb begin
    data_o = 32'd0;
    if (v_i) begin
      case (word_idx_i)
        E_DATA:    data_o = entry_i[31:0];
        E_ADDR:    data_o = entry_i[63:32];
        E_MASK_WE: data_o = entry_i[95:64];
        E_SRC:     data_o = entry_i[127:96];
`ifdef BSG_HOST_REQ_FIFO_TIMESTAMP_EN
        E_TIME:    data_o = entry_i[159:128];
`else
        E_TIME:    data_o = 32'd0;
`endif
        default:   data_o = 32'd0;
      endcase
    end else begin
      data_o = 32'd0;
    end
  end

endmodule

// File: rtl/bsg_manycore_host_request_fifo_chk.sv
// Protocol assertions for the host request FIFO.
module bsg_manycore_host_request_fifo_chk #(
  parameter int els_p         = 16,
  parameter int count_width_p = 5
) (
  input logic                     clk_i,
  input logic                     reset_ni,
  input logic                     host_yumi_i,
  input logic                     host_v_i,
  input logic [count_width_p-1:0] count_i
);

  a_yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_ni) host_yumi_i |-> host_v_i);

  a_count_in_range: assert property (
    @(posedge clk_i) disable iff (!reset_ni) count_i <= count_width_p'(els_p));

endmodule

// File: rtl/bsg_mem_1r1w.sv
// Simple one-write-port, one-asynchronous-read-port register-file memory.
module bsg_mem_1r1w #(
  parameter int width_p = 32,
  parameter int els_p   = 16,
  localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Storage write port; contents are not reset.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i & ~w_reset_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = r_v_i ? mem_q[r_addr_i] : {width_p{1'b0}};

endmodule

// File: rtl/bsg_manycore_host_request_fifo.sv
// Packet FIFO between the request timer and the host word-pop interface.
// Optional feature macro: BSG_HOST_REQ_FIFO_TIMESTAMP_EN (timestamp stored as word 4).
module bsg_manycore_host_request_fifo
  import bsg_manycore_host_req_pkg::*;
#(
  parameter int x_cord_width_p = 8,
  parameter int y_cord_width_p = 8,
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int els_p          = 16,
  localparam int ptr_width_lp   = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p) + 1,
  localparam int mask_width_lp  = data_width_p >> 3,
  localparam int entry_width_lp = host_req_words_gp * 32
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      v_i,
  output logic                      rdy_o,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [mask_width_lp-1:0]  mask_i,
  input  logic [addr_width_p-1:0]   addr_i,
  input  logic                      we_i,
  input  logic [x_cord_width_p-1:0] src_x_cord_i,
  input  logic [y_cord_width_p-1:0] src_y_cord_i,
  output logic                      host_v_o,
  output logic [31:0]               host_data_o,
  input  logic                      host_yumi_i,
  input  logic                      host_clear_i,
  output logic [count_width_lp-1:0] count_o
);

  logic [ptr_width_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [count_width_lp-1:0] count_q, count_d;
  host_req_word_e            word_idx_q, word_idx_d;
  logic                      full_s, enq_s, pop_s, retire_s;
  logic [31:0]               word2_s, word3_s;
  logic [entry_width_lp-1:0] w_entry_s, r_entry_s;

  // rdy_o is deliberately independent of v_i: upstream valid is derived from it.
  assign full_s   = (count_q == count_width_lp'(els_p));
  assign rdy_o    = reset_ni & ~full_s & ~host_clear_i;
  assign host_v_o = (count_q != {count_width_lp{1'b0}});
  assign enq_s    = v_i & rdy_o;
  assign pop_s    = host_yumi_i & host_v_o;
  assign retire_s = pop_s & (word_idx_q == host_req_last_word_gp);
  assign count_o  = count_q;

  // Formats the control and source words of an incoming request.
  always_comb begin
    word2_s = 32'd0;
    word2_s[host_req_we_bit_gp] = we_i;
    word2_s[mask_width_lp-1:0] = mask_i;
    word3_s = 32'd0;
    word3_s[x_cord_width_p-1:0] = src_x_cord_i;
    word3_s[host_req_src_y_offset_gp +: y_cord_width_p] = src_y_cord_i;
  end

`ifdef BSG_HOST_REQ_FIFO_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  assign ts_d = ts_q + 32'd1;

  // Free-running cycle counter captured with each packet.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign w_entry_s = {ts_q, word3_s, word2_s, 32'(addr_i), data_i};
`else
  assign w_entry_s = {word3_s, word2_s, 32'(addr_i), data_i};
`endif

  // Next-state for pointers, packet count and head word index.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    if (host_clear_i) begin
      wptr_d     = {ptr_width_lp{1'b0}};
      rptr_d     = {ptr_width_lp{1'b0}};
      count_d    = {count_width_lp{1'b0}};
      word_idx_d = E_DATA;
    end else begin
      if (enq_s) begin
        wptr_d = wptr_q + ptr_width_lp'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        word_idx_d = host_req_next_word(word_idx_q);
      end else begin
        word_idx_d = word_idx_q;
      end
      if (retire_s) begin
        rptr_d = rptr_q + ptr_width_lp'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({enq_s, retire_s})
        2'b10:   count_d = count_q + count_width_lp'(1);
        2'b01:   count_d = count_q - count_width_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wptr_q     <= {ptr_width_lp{1'b0}};
      rptr_q     <= {ptr_width_lp{1'b0}};
      count_q    <= {count_width_lp{1'b0}};
      word_idx_q <= E_DATA;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
    end
  end

  bsg_mem_1r1w #(
    .width_p(entry_width_lp),
    .els_p  (els_p)
  ) mem (
    .w_clk_i  (clk_i),
    .w_reset_i(~reset_ni),
    .w_v_i    (enq_s),
    .w_addr_i (wptr_q),
    .w_data_i (w_entry_s),
    .r_v_i    (host_v_o),
    .r_addr_i (rptr_q),
    .r_data_o (r_entry_s)
  );

  bsg_manycore_host_req_word_sel word_sel (
    .entry_i   (r_entry_s),
    .v_i       (host_v_o),
    .word_idx_i(word_idx_q),
    .data_o    (host_data_o)
  );

  bsg_manycore_host_request_fifo_chk #(
    .els_p        (els_p),
    .count_width_p(count_width_lp)
  ) chk (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .host_yumi_i(host_yumi_i),
    .host_v_i   (host_v_o),
    .count_i    (count_q)
  );

endmodule

// File: tb/tb_bsg_manycore_host_request_fifo.sv
// Randomized bench for the host request FIFO with a queue-based packet model.
// Optional feature macro: BSG_HOST_REQ_FIFO_TIMESTAMP_EN.
module tb_bsg_manycore_host_request_fifo;

  localparam int X_W = 8;
  localparam int Y_W = 8;
  localparam int A_W = 28;
  localparam int ELS = 16;
`ifdef BSG_HOST_REQ_FIFO_TIMESTAMP_EN
  localparam int WORDS = 5;
`else
  localparam int WORDS = 4;
`endif

  typedef logic [4:0][31:0] pkt_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           v_i = 1'b0;
  logic           rdy_o;
  logic [31:0]    data_i = 32'd0;
  logic [3:0]     mask_i = 4'd0;
  logic [A_W-1:0] addr_i = '0;
  logic           we_i = 1'b0;
  logic [X_W-1:0] x_i = '0;
  logic [Y_W-1:0] y_i = '0;
  logic           host_v_o;
  logic [31:0]    host_data_o;
  logic           host_yumi_i = 1'b0;
  logic           host_clear_i = 1'b0;
  logic [4:0]     count_o;

  pkt_t        mq[$];
  int          midx = 0;
  logic [31:0] mts = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bsg_manycore_host_request_fifo #(
    .x_cord_width_p(X_W), .y_cord_width_p(Y_W), .addr_width_p(A_W),
    .data_width_p(32), .els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .v_i(v_i), .rdy_o(rdy_o), .data_i(data_i),
    .mask_i(mask_i), .addr_i(addr_i), .we_i(we_i), .src_x_cord_i(x_i),
    .src_y_cord_i(y_i), .host_v_o(host_v_o), .host_data_o(host_data_o),
    .host_yumi_i(host_yumi_i), .host_clear_i(host_clear_i), .count_o(count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t make_pkt(input logic [31:0] d, input logic [A_W-1:0] a,
                                    input logic we, input logic [3:0] m,
                                    input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                    input logic [31:0] ts);
    pkt_t p;
    p[0] = d;
    p[1] = 32'(a);
    p[2] = (32'(we) * 32'd16) + 32'(m);
    p[3] = (32'(y) * 32'd65536) + 32'(x);
    p[4] = ts;
    return p;
  endfunction

  // Reference model: whole packets in a queue plus the word position of the head.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      midx = 0;
      mts = 32'd0;
    end else begin
      bit take;
      take = v_i && (mq.size() != ELS) && !host_clear_i;
      if (host_clear_i) begin
        mq.delete();
        midx = 0;
      end else begin
        if (host_yumi_i && mq.size() != 0) begin
          midx++;
          if (midx == WORDS) begin
            void'(mq.pop_front());
            midx = 0;
          end
        end
        if (take) mq.push_back(make_pkt(data_i, addr_i, we_i, mask_i, x_i, y_i, mts));
      end
      mts = mts + 32'd1;
    end
  end

  // Compare process: DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    logic [31:0] exp_data;
    logic        exp_v;
    exp_v    = (mq.size() != 0);
    exp_data = exp_v ? mq[0][midx] : 32'd0;
    check("count", 32'(count_o), 32'(mq.size()));
    check("host_v", 32'(host_v_o), 32'(exp_v));
    check("host_data", host_data_o, exp_data);
    check("rdy", 32'(rdy_o), 32'(rst_n && (mq.size() != ELS) && !host_clear_i));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_i = 1'b0;
    host_yumi_i = 1'b0;
    host_clear_i = 1'b0;
  endtask

  task automatic rand_req();
    data_i = $urandom;
    addr_i = A_W'($urandom);
    we_i   = 1'($urandom);
    mask_i = 4'($urandom);
    x_i    = X_W'($urandom);
    y_i    = Y_W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < ELS * WORDS + 4; i++) begin
      host_yumi_i = (mq.size() != 0);
      cyc();
    end
    host_yumi_i = 1'b0;
    check("drain_empty", 32'(count_o), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hDEADBEEF;
    exp_w[1] = 32'h00003AB5;
    exp_w[2] = 32'h0000001F;
    exp_w[3] = 32'h00030002;

    // Reset state, with v_i held high to show nothing enters.
    idle();
    v_i = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("reset_rdy", 32'(rdy_o), 32'd0);
    check("reset_host_v", 32'(host_v_o), 32'd0);
    check("reset_data", host_data_o, 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    v_i = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single known packet read back word by word.
    data_i = 32'hDEADBEEF; addr_i = A_W'(32'h3AB5); we_i = 1'b1;
    mask_i = 4'hF; x_i = X_W'(2); y_i = Y_W'(3);
    v_i = 1'b1;
    cyc();
    v_i = 1'b0;
    check("pkt_a_v", 32'(host_v_o), 32'd1);
    check("pkt_a_count", 32'(count_o), 32'd1);
    for (int i = 0; i < WORDS; i++) begin
      if (i < 4) check("pkt_a_word", host_data_o, exp_w[i]);
      host_yumi_i = 1'b1;
      cyc();
    end
    host_yumi_i = 1'b0;
    check("pkt_a_count_end", 32'(count_o), 32'd0);
    check("pkt_a_v_end", 32'(host_v_o), 32'd0);

    // Fill to capacity, then retire one while a request is held.
    v_i = 1'b1;
    for (int i = 0; i < ELS; i++) begin
      rand_req();
      cyc();
    end
    check("full_rdy", 32'(rdy_o), 32'd0);
    check("full_count", 32'(count_o), 32'd16);
    rand_req();
    host_yumi_i = 1'b1;
    repeat (WORDS) cyc();
    host_yumi_i = 1'b0;
    check("after_retire_rdy", 32'(rdy_o), 32'd1);
    check("after_retire_count", 32'(count_o), 32'd15);
    cyc();
    v_i = 1'b0;
    check("held_enq_count", 32'(count_o), 32'd16);
    drain();

    // Retire and enqueue in the same cycle at count 1.
    rand_req();
    v_i = 1'b1;
    cyc();
    v_i = 1'b0;
    host_yumi_i = 1'b1;
    repeat (WORDS - 1) cyc();
    rand_req();
    data_i = 32'h12345678;
    v_i = 1'b1;
    cyc();
    idle();
    check("swap_count", 32'(count_o), 32'd1);
    check("swap_word0", host_data_o, 32'h12345678);
    drain();

    // Clear mid-packet with a request pending.
    v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_req();
      cyc();
    end
    v_i = 1'b0;
    host_yumi_i = 1'b1;
    repeat (2) cyc();
    host_yumi_i = 1'b0;
    check("pre_clear_count", 32'(count_o), 32'd5);
    host_clear_i = 1'b1;
    v_i = 1'b1;
    #1;
    check("clear_rdy", 32'(rdy_o), 32'd0);
    cyc();
    idle();
    check("post_clear_count", 32'(count_o), 32'd0);
    check("post_clear_v", 32'(host_v_o), 32'd0);
    check("post_clear_data", host_data_o, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_req();
      v_i          = ($urandom_range(0, 99) < 60);
      host_yumi_i  = (mq.size() != 0) && ($urandom_range(0, 99) < 55);
      host_clear_i = ($urandom_range(0, 199) == 0);
      cyc();
    end
    idle();

    // Asynchronous reset between edges while mid-packet.
    v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      cyc();
    end
    v_i = 1'b0;
    host_yumi_i = 1'b1;
    cyc();
    host_yumi_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rdy", 32'(rdy_o), 32'd0);
    check("async_rst_v", 32'(host_v_o), 32'd0);
    check("async_rst_data", host_data_o, 32'd0);
    check("async_rst_count", 32'(count_o), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

`ifdef BSG_HOST_REQ_FIFO_TIMESTAMP_EN
    // Timestamp captured at the 100th cycle after reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (100) cyc();
    rand_req();
    v_i = 1'b1;
    cyc();
    v_i = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == 4) check("ts_word", host_data_o, 32'd100);
      host_yumi_i = 1'b1;
      cyc();
    end
    host_yumi_i = 1'b0;
    check("ts_count_end", 32'(count_o), 32'd0);
`endif

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bsg_manycore_host_request_fifo.md
Name: bsg_manycore_host_request_fifo

Overview:
- Downstream neighbour of the manycore endpoint request timer: consumes its valid/ready request stream and buffers whole request packets.
- Presents each buffered packet to the host as a sequence of 32-bit words on a valid/yumi pop interface.
- Host polls and drains the words; a host clear flushes the buffer.

Parameters:
- x_cord_width_p, "inv", source x-coordinate width; must be ≤ 16.
- y_cord_width_p, "inv", source y-coordinate width; must be ≤ 16.
- addr_width_p, "inv", request address width; must be ≤ 32.
- data_width_p, 32, request data width; only 32 is legal.
- els_p, 16, packet capacity; power of 2, ≥ 2.

Ports:
- clk_i  in  1  sole clock.
- reset_ni  in  1  asynchronous, active-low reset.
- v_i  in  1  request valid from upstream.
- rdy_o  out  1  ready to accept a request.
- data_i  in  data_width_p  request data.
- mask_i  in  data_width_p>>3  byte mask.
- addr_i  in  addr_width_p  request address.
- we_i  in  1  write enable.
- src_x_cord_i  in  x_cord_width_p  source x.
- src_y_cord_i  in  y_cord_width_p  source y.
- host_v_o  out  1  head word valid.
- host_data_o  out  32  head word.
- host_yumi_i  in  1  host consumes head word.
- host_clear_i  in  1  synchronous flush.
- count_o  out  $clog2(els_p)+1  packets held.

Behaviour:
- Reset (reset_ni=0, asynchronous): write pointer, read pointer, count_o and word_idx all 0.
  - While in reset: rdy_o=0, host_v_o=0, host_data_o=0.
- rdy_o = (count_o != els_p) & ~host_clear_i.
  - Must not depend on v_i; upstream v_o is combinational on rdy_o.
- Enqueue fires when v_i & rdy_o; the fields are written into the entry at the write pointer.
- Packet word layout, word_idx 0..3:
  - W0 = data_i.
  - W1 = addr_i, zero-extended.
  - W2 = {zero, we_i at bit 4, mask_i at bits 3:0}.
  - W3 = {zero, src_y at bit 16 upward, src_x at bit 0 upward}.
- host_v_o = (count_o != 0).
- host_data_o = word[word_idx] of the head entry when host_v_o=1; 0 otherwise.
- Latency: a packet enqueued at cycle N has host_v_o=1 with W0 at cycle N+1. There is no same-cycle bypass.
- Pop of a word (host_yumi_i & host_v_o):
  - word_idx < last: word_idx increments.
  - word_idx = last: read pointer increments, word_idx returns to 0, and the packet retires.
- host_yumi_i while host_v_o=0 is ignored and flagged by an assertion.
- Count update: +1 on enqueue only; −1 on retire only; unchanged when both happen in the same cycle.
- Full plus retire in the same cycle: rdy_o stays 0 that cycle and becomes 1 the next cycle.
- Pointers wrap modulo els_p; the full/empty distinction comes from count_o.
- host_clear_i=1: the next state is count 0, pointers 0, word_idx 0. Clear overrides a simultaneous yumi; no enqueue can occur because rdy_o=0.
- Reset asserted mid-packet: the partial word sequence is lost and no state is retained.

Optional Feature:
- Macro BSG_HOST_REQ_FIFO_TIMESTAMP_EN.
- Defined:
  - An internal 32-bit free-running cycle counter resets to 0 and increments every cycle.
  - Its value at enqueue is stored with the packet as W4; packet length becomes 5 words and last = 4.
  - The counter wraps 0xFFFFFFFF→0.
- Undefined: 4 words per packet, last = 3, no counter.

Decomposition:
- Package bsg_manycore_host_req_pkg holds:
  - Word-count constants: 4, and 5 with the timestamp.
  - word_idx enum: E_DATA, E_ADDR, E_MASK_WE, E_SRC, E_TIME.
  - Field bit offsets: we bit 4, src_y offset 16.
- Storage uses the existing bsg_mem_1r1w.
- One natural sub-module: bsg_manycore_host_req_word_sel, which maps the head entry and word_idx to host_data_o.

Test Plan:
- Reset, then enqueue data=0xDEADBEEF, addr=0x3AB5, we=1, mask=0xF, x=2, y=3.
  - Next cycle host_v_o=1.
  - Words read back as 0xDEADBEEF, 0x3AB5, 0x1F, 0x00030002.
  - count_o reaches 0 after the 4th yumi.
- Fill 16 packets with no yumi.
  - rdy_o=0 at count_o=16.
  - Retire one packet while v_i is held: rdy_o=1 the next cycle, and the held packet enqueues with count_o back at 16.
- At count_o=1 with word_idx=3, yumi and enqueue in the same cycle → count_o stays 1 and the new packet's W0 appears.
- Assert host_clear_i mid-packet (word_idx=2, count_o=5) with v_i=1.
  - rdy_o=0 during clear.
  - Next cycle count_o=0, host_v_o=0, host_data_o=0.
- Assert reset_ni low between clock edges mid-stream → outputs go to reset values immediately, without waiting for a clock edge.
- With BSG_HOST_REQ_FIFO_TIMESTAMP_EN, enqueue at cycle 100 after reset → W4=100; five yumis retire the packet.
